// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file widths, zero-register index and ALU control codes
package reg_file_pkg;
    localparam int RF_DATA_W = 64;
    localparam int RF_ADDR_W = 5;
    localparam int RF_ZR_IDX = 31;
    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_op_t;
endpackage

// File: rtl/reg_file_read_port.sv
// rf_read_port: address decode with zero-register override and optional write bypass
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int ZR_IDX = RF_ZR_IDX,
    parameter bit BYPASS = 1'b1
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);
    logic zr_hit;
    logic byp_hit;
    assign zr_hit  = ra == ADDR_W'(ZR_IDX);
    assign byp_hit = BYPASS && we && wa == ra;
    assign rd = (!rst_n || zr_hit) ? '0 : byp_hit ? wd : regs[ra];
endmodule

// File: rtl/reg_file.sv
// reg_file: 31 x DATA_W flop register file with hardwired zero register and bypassed reads
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int ZR_IDX = RF_ZR_IDX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_d
);
    localparam int NREGS = 2**ADDR_W;
    logic [DATA_W-1:0] x [NREGS];
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == ZR_IDX) begin : g_zr
            assign x[i] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] q;
            // register i: async clear, loads wd when addressed by an enabled write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else if (we && wa == ADDR_W'(i)) q <= wd;
            end
            assign x[i] = q;
        end
    end
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZR_IDX(ZR_IDX), .BYPASS(1'b1)) u_rp1 (
        .rst_n(rst_n), .ra(ra1), .regs(x), .we(we), .wa(wa), .wd(wd), .rd(rd1)
    );
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZR_IDX(ZR_IDX), .BYPASS(1'b1)) u_rp2 (
        .rst_n(rst_n), .ra(ra2), .regs(x), .we(we), .wa(wa), .wd(wd), .rd(rd2)
    );
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZR_IDX(ZR_IDX), .BYPASS(1'b0)) u_rpd (
        .rst_n(rst_n), .ra(dbg_a), .regs(x), .we(we), .wa(wa), .wd(wd), .rd(dbg_d)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed stimulus against an array model of the register file
module tb_reg_file;
    import reg_file_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, dbg_a = '0;
    logic [63:0] wd = '0;
    logic        we = 1'b0;
    logic [63:0] rd1, rd2, dbg_d;
    logic [63:0] model [32] = '{default: 64'd0};
    int total = 0;
    int bad = 0;

    reg_file dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd), .we(we),
        .rd1(rd1), .rd2(rd2), .dbg_a(dbg_a), .dbg_d(dbg_d)
    );

    always #5 clk = ~clk;

    // architectural state: 31 storage slots, X31 never stored, reset wipes everything
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) model[k] = 64'd0;
        end else if (we && wa != 5'd31) begin
            model[wa] = wd;
        end
    end

    function automatic logic [63:0] expect_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd31) return 64'd0;
        if (byp && we && wa == a) return wd;
        return model[a];
    endfunction

    function automatic logic [63:0] alu(input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            ALU_AND:   return a & b;
            ALU_ORR:   return a | b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_PASSB: return b;
            default:   return 64'd0;
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic cmp_model();
        chk("cyc_rd1", rd1, expect_rd(ra1, 1'b1));
        chk("cyc_rd2", rd2, expect_rd(ra2, 1'b1));
        chk("cyc_dbg", dbg_d, expect_rd(dbg_a, 1'b0));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic sweep();
        for (int a = 0; a < 32; a++) begin
            dbg_a = 5'(a);
            #1;
            chk("sweep", dbg_d, expect_rd(5'(a), 1'b0));
        end
    endtask

    logic [63:0] r;

    initial begin
        // reset held: reads zero, bypass suppressed, coinciding write lost
        ra1 = 5'd3; ra2 = 5'd3; we = 1'b1; wa = 5'd3; wd = 64'h5;
        #1;
        chk("rst_rd1", rd1, 64'd0);
        chk("rst_rd2_nobyp", rd2, 64'd0);
        tick();
        tick();
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        dbg_a = 5'd3;
        #1;
        chk("rst_write_lost", dbg_d, 64'd0);
        tick();

        // async reset mid-cycle clears immediately
        wr(5'd5, 64'h1234);
        dbg_a = 5'd5; ra1 = 5'd5;
        #1;
        chk("x5_written", dbg_d, 64'h1234);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dbg", dbg_d, 64'd0);
        chk("async_rst_rd1", rd1, 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("after_rst_x5", dbg_d, 64'd0);

        // write then read
        wr(5'd9, 64'hDEADBEEFCAFEF00D);
        ra1 = 5'd9;
        #1;
        chk("wr_rd_x9", rd1, 64'hDEADBEEFCAFEF00D);

        // zero register write discarded
        ra1 = 5'd31; we = 1'b1; wa = 5'd31; wd = 64'hFFFFFFFFFFFFFFFF;
        #1;
        chk("xzr_before", rd1, 64'd0);
        tick();
        we = 1'b0;
        #1;
        chk("xzr_after", rd1, 64'd0);
        sweep();
        dbg_a = 5'd9;
        #1;
        chk("xzr_x9_kept", dbg_d, 64'hDEADBEEFCAFEF00D);

        // bypass: new data on read ports, old data on debug until the edge
        wr(5'd3, 64'h10);
        we = 1'b1; wa = 5'd3; wd = 64'h20; ra1 = 5'd3; ra2 = 5'd3; dbg_a = 5'd3;
        #1;
        chk("byp_rd1", rd1, 64'h20);
        chk("byp_rd2", rd2, 64'h20);
        chk("byp_dbg_old", dbg_d, 64'h10);
        tick();
        we = 1'b0;
        #1;
        chk("byp_dbg_new", dbg_d, 64'h20);

        // write inhibit, including unknown address/data
        wr(5'd7, 64'h55);
        wa = 5'd7; wd = 64'hAA;
        for (int k = 0; k < 3; k++) tick();
        wa = 'x; wd = 'x;
        tick();
        wa = '0; wd = '0; dbg_a = 5'd7;
        #1;
        chk("inhibit_x7", dbg_d, 64'h55);

        // ALU pairing through both read ports
        wr(5'd1, 64'd5);
        wr(5'd2, 64'd5);
        ra1 = 5'd1; ra2 = 5'd2;
        #1;
        r = alu(ALU_SUB, rd1, rd2);
        chk("alu_sub_r", r, 64'd0);
        chk("alu_sub_zero", {63'd0, r == 64'd0}, 64'd1);
        wr(5'd1, 64'hF0);
        wr(5'd2, 64'h0F);
        #1;
        r = alu(ALU_ORR, rd1, rd2);
        chk("alu_orr_r", r, 64'hFF);
        chk("alu_orr_zero", {63'd0, r == 64'd0}, 64'd0);

        // fill every address with a distinct pattern, reading neighbours as it goes
        for (int k = 0; k < 32; k++) begin
            ra1 = 5'(k); ra2 = 5'(k + 1); dbg_a = 5'(k);
            wr(5'(k), {32'(k) * 32'h01010101, ~(32'(k) * 32'h00100001)});
        end
        sweep();
        dbg_a = 5'd17;
        #1;
        chk("fill_x17", dbg_d, {32'h11111111, ~32'h01100011});
        dbg_a = 5'd31;
        #1;
        chk("fill_x31", dbg_d, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, 64, register and data-path width in bits.
REQ-002 Parameter ADDR_W, 5, register address width; register count is 2**ADDR_W = 32.
REQ-003 Parameter ZR_IDX, 31, index of the hardwired zero register (XZR).
REQ-004 Port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port RST_N  input  1  reset, asynchronous and active-low.
REQ-006 Port RA1  input  ADDR_W  read address, port 1; RD1 drives the ALU A operand.
REQ-007 Port RA2  input  ADDR_W  read address, port 2; RD2 drives the store data or ALU B-mux register input.
REQ-008 Port WA  input  ADDR_W  write address.
REQ-009 Port WD  input  DATA_W  write data from the write-back mux, ALU R or memory load.
REQ-010 Port WE  input  1  write enable, sampled at the CLK rising edge.
REQ-011 Port RD1  output  DATA_W  read data, port 1.
REQ-012 Port RD2  output  DATA_W  read data, port 2.
REQ-013 Port DBG_A  input  ADDR_W  debug/testbench read address.
REQ-014 Port DBG_D  output  DATA_W  debug read data; uses the same rules as RD1/RD2, without bypass.

Function
REQ-015 Storage SHALL be 31 DATA_W-bit registers, X0..X30; ZR_IDX SHALL have no storage.
REQ-016 Reads SHALL be combinational: RDn = X[RAn] in the same cycle, with zero clock latency.
REQ-017 A read of ZR_IDX on any port SHALL return 0 at all times.
REQ-018 A write SHALL occur only at the CLK rising edge with WE=1 and RST_N=1; X[WA] takes WD.
REQ-019 A write with WA=ZR_IDX SHALL be discarded; no register SHALL change.
REQ-020 WE=0 SHALL leave every register unchanged, regardless of WA and WD.
REQ-021 Bypass: when WE=1, WA=RAn and WA!=ZR_IDX, RDn SHALL equal WD combinationally in the same cycle, giving write-then-read visibility.
REQ-022 RA1=RA2 SHALL return identical data on both ports, including the bypass case.
REQ-023 X/Z on WA or WD with WE=0 SHALL NOT corrupt state.
REQ-024 Only one write per cycle; no write-collision case exists.

Reset
REQ-025 RST_N=0 SHALL clear X0..X30 to 0 immediately, without waiting for CLK.
REQ-026 During reset, RD1, RD2 and DBG_D SHALL read 0 for every address, and bypass SHALL be suppressed.
REQ-027 A write whose edge coincides with RST_N=0 SHALL be lost.
REQ-028 The first write SHALL take effect on the first CLK rising edge that occurs after RST_N rises.

Structure
REQ-029 Shared package SHALL hold DATA_W, ADDR_W, ZR_IDX and the ALU control codes: AND=0000, ORR=0001, ADD=0010, SUB=0110, PASSB=0111.
REQ-030 Sub-module rf_read_port SHALL implement the address decode, the zero-register check and the bypass compare.
REQ-031 rf_read_port SHALL be instantiated three times: twice with bypass enabled for RD1/RD2, once with bypass disabled for DBG_D.
REQ-032 Storage SHALL be a flop array; no memory macro.

Verification
REQ-033 Reset test: write X5=0x1234, pulse RST_N low mid-cycle -> DBG_D and RD1 read 0 immediately, before the next CLK edge.
REQ-034 Write/read test: WE=1, WA=9, WD=0xDEADBEEFCAFEF00D, one edge, then RA1=9 -> RD1=0xDEADBEEFCAFEF00D.
REQ-035 XZR test: WE=1, WA=31, WD=0xFFFFFFFFFFFFFFFF -> RD1 with RA1=31 reads 0 before and after the edge; all other registers unchanged.
REQ-036 Bypass test: X3=0x10; in one cycle WE=1, WA=3, WD=0x20, RA1=RA2=3 -> RD1=RD2=0x20 before the edge, while DBG_D (DBG_A=3) reads 0x10 until the edge.
REQ-037 Write-inhibit test: X7=0x55, then WE=0, WA=7, WD=0xAA for 3 edges -> X7 stays 0x55.
REQ-038 ALU pairing test: X1=5 and X2=5 feed the ALU with code 0110 -> R=0 and ZERO=1; X1=0xF0, X2=0x0F with code 0001 -> R=0xFF and ZERO=0.
